tx_frame_scheduler: RTL and testbench
=====================================

// Module: tx_frame_scheduler
// PURPOSE
//  Shares the HDLC transmit framer between NSRC byte-stream sources (host TX FIFO, bridge forward FIFO).
//  - Grants whole frames round-robin.
//  - Drives the framer's byte handshake (data_in / data_available / data_consumed / eop).
//  - Enforces post-frame hold and inter-frame flag gap via flag_fill.
//  - Reports framer underruns back to the offending source.
//  Runs on netclk rising edge; the framer updates on the falling edge, so every signal crossing between them has half a bit-time of margin.
// PARAMETERS
//  NSRC       2   number of requesting sources (2..4)
//  EOP_HOLD   40  bit-times eop is held after last byte is taken (covers 8 data + 16 FCS + 8 flag + stuffing)
//  GAP_FLAGS  1   whole flags (8 bit-times each) of flag_fill between frames; 0 = no gap
// PORTS
//  netclk         in   1        bit clock, shared with framer
//  reset          in   1        asynchronous, active-high
//  tx_enable      in   1        0 = grant no new frames; a frame in progress completes
//  cfg_flag_idle  in   1        1 = flag_fill held high whenever IDLE (continuous flag idle)
//  src_valid      in   NSRC     per-source byte valid; a source requests by holding it high
//  src_data       in   8*NSRC   per-source byte, source i at [8i+7:8i]
//  src_last       in   NSRC     byte presented is the final byte of the frame
//  src_ready      out  NSRC     1-cycle pulse: byte accepted by the framer
//  src_abort      out  NSRC     1-cycle pulse: granted frame aborted (underrun)
//  grant          out  NSRC     one-hot owner of the framer; 0 when idle
//  busy           out  1        state != IDLE
//  fr_data_in     out  8        to framer data_in
//  fr_data_avail  out  1        to framer data_available
//  fr_consumed    in   1        from framer data_consumed
//  fr_eop         out  1        to framer eop
//  fr_flag_fill   out  1        to framer flag_fill
//  fr_underrun    in   1        from framer underrun (sticky in framer)
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, rr pointer = source 0, edge-detect registers cleared.
//  - States:
//    - IDLE: if tx_enable and any src_valid, latch the round-robin winner into grant (pointer then moves past the winner) -> SEND.
//    - SEND:
//      - fr_data_in = src_data[grant]; fr_data_avail = src_valid[grant] & ~eop_r.
//      - Each rising edge of fr_consumed (edge-detected; the level may persist 2 cycles when a zero-stuff follows the load) pulses src_ready[grant] once.
//      - If that byte had src_last=1: set fr_eop, load the hold counter with EOP_HOLD -> TAIL.
//      - Rising edge of fr_underrun: pulse src_abort[grant], clear grant -> GAP.
//    - TAIL: fr_data_avail=0, fr_eop=1; count down once per cycle; at 0, clear fr_eop and grant -> GAP.
//    - GAP: fr_flag_fill=1 for GAP_FLAGS*8 cycles -> IDLE; GAP_FLAGS=0 goes straight to IDLE.
//  - fr_flag_fill = (state==GAP) | (state==IDLE & cfg_flag_idle).
//  - 1-byte frame: src_last on the first byte sets eop before the framer's next byte boundary; legal.
//  - Source drops src_valid mid-frame: no data presented at the boundary, so the framer aborts; handled via the underrun edge.
//  - Framer underrun is sticky: after the first abort, later underruns are not detected until reset.
//  - tx_enable fall during SEND/TAIL/GAP: no effect until IDLE.
//  - Simultaneous requests: the lowest index at or after the rr pointer wins.
//  - Reset mid-frame: immediate return to IDLE; no src_abort is generated.
// CONFIGURATION
//  - TX_SCHED_STATS_EN defined: adds outputs stat_frames[15:0] (+1 on TAIL->GAP) and stat_aborts[15:0] (+1 per src_abort); both wrap at 16'hFFFF and clear on reset.
//  - Undefined: ports and counters absent; behaviour otherwise identical.
// STRUCTURE
//  - Package eb3_tx_pkg: state encoding localparams (IDLE/SEND/TAIL/GAP) and counter width constant (7 bits).
//  - Sub-module rr_arbiter (NSRC-wide request in, one-hot grant out, advance strobe) instantiated once.
// TESTING
//  - NSRC=2, src0 sends 3 bytes 0x11,0x22,0x33(last): exactly 3 src_ready[0] pulses; fr_eop high 40 cycles; then 8 cycles flag_fill; busy returns to 0.
//  - src0 and src1 valid together, repeatedly: grants alternate 0,1,0,1.
//  - Data 0xFF bytes (zero-stuff): fr_consumed held 2 cycles -> still exactly one src_ready per byte.
//  - src1 drops valid after byte 2 -> framer underrun rises -> one src_abort[1] pulse, GAP, grant=0.
//  - cfg_flag_idle=1, no requests: fr_flag_fill stays 1 in IDLE; tx_enable=0 with src_valid=1: no grant.
//  - Reset asserted mid-TAIL: all outputs 0 asynchronously; with TX_SCHED_STATS_EN, the frame counter is not incremented.

Source files
------------

// File: rtl/eb3_tx_pkg.sv
// Shared types and constants for the HDLC transmit frame scheduler.
package eb3_tx_pkg;

    localparam int unsigned CNT_W = 7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_TAIL = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: lowest requesting index at or after the pointer wins;
// the pointer moves past the winner when advance is strobed.
module rr_arbiter #(
    parameter int unsigned NSRC = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NSRC-1:0] req,
    input  logic            advance,
    output logic [NSRC-1:0] gnt_c
);

    localparam int unsigned PTR_W = (NSRC > 2) ? 2 : 1;

    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] idx_hi;
    logic [PTR_W-1:0] idx_lo;
    logic [PTR_W-1:0] win_idx;
    logic             hit_hi;
    logic             hit_lo;

    // Descending scan leaves the lowest matching index in each candidate.
    always_comb begin
        hit_hi = 1'b0;
        hit_lo = 1'b0;
        idx_hi = '0;
        idx_lo = '0;
        for (int j = NSRC - 1; j >= 0; j--) begin
            if (req[j]) begin
                hit_lo = 1'b1;
                idx_lo = PTR_W'(j);
                if (PTR_W'(j) >= ptr) begin
                    hit_hi = 1'b1;
                    idx_hi = PTR_W'(j);
                end
            end
        end
        win_idx = hit_hi ? idx_hi : idx_lo;
        gnt_c   = '0;
        if (hit_lo) begin
            gnt_c[win_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr <= '0;
        end else if (advance && hit_lo) begin
            ptr <= (win_idx == PTR_W'(NSRC - 1)) ? '0 : win_idx + PTR_W'(1);
        end
    end

endmodule

// File: rtl/tx_frame_scheduler.sv
// Grants whole frames from NSRC byte sources to one HDLC framer, with eop hold and flag gap.
// Optional TX_SCHED_STATS_EN adds frame/abort counters.
module tx_frame_scheduler
    import eb3_tx_pkg::*;
#(
    parameter int unsigned NSRC      = 2,
    parameter int unsigned EOP_HOLD  = 40,
    parameter int unsigned GAP_FLAGS = 1
) (
    input  logic              netclk,
    input  logic              reset,
    input  logic              tx_enable,
    input  logic              cfg_flag_idle,
    input  logic [NSRC-1:0]   src_valid,
    input  logic [8*NSRC-1:0] src_data,
    input  logic [NSRC-1:0]   src_last,
    output logic [NSRC-1:0]   src_ready,
    output logic [NSRC-1:0]   src_abort,
    output logic [NSRC-1:0]   grant,
    output logic              busy,
    output logic [7:0]        fr_data_in,
    output logic              fr_data_avail,
    input  logic              fr_consumed,
    output logic              fr_eop,
    output logic              fr_flag_fill,
`ifdef TX_SCHED_STATS_EN
    output logic [15:0]       stat_frames,
    output logic [15:0]       stat_aborts,
`endif
    input  logic              fr_underrun
);

    localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(EOP_HOLD);
    localparam logic [CNT_W-1:0] GAP_LD  = CNT_W'(GAP_FLAGS * 8);
    localparam state_t           POST_ST = (GAP_FLAGS != 0) ? ST_GAP : ST_IDLE;

    state_t           state;
    state_t           nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [NSRC-1:0]  grant_nxt;
    logic [NSRC-1:0]  rdy_nxt;
    logic [NSRC-1:0]  abt_nxt;
    logic             eop_nxt;
    logic             cons_d;
    logic             und_d;
    logic             cons_rise;
    logic             und_rise;
    logic [NSRC-1:0]  arb_gnt_c;
    logic             arb_adv;
    logic [7:0]       sel_data;
    logic             sel_valid;
    logic             sel_last;

    rr_arbiter #(.NSRC(NSRC)) u_arb (
        .clk     (netclk),
        .reset   (reset),
        .req     (src_valid),
        .advance (arb_adv),
        .gnt_c   (arb_gnt_c)
    );

    // One-hot grant mux; yields zeros when nothing is granted.
    always_comb begin
        sel_data  = '0;
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            if (grant[i]) begin
                sel_data  = sel_data | src_data[8*i +: 8];
                sel_valid = sel_valid | src_valid[i];
                sel_last  = sel_last | src_last[i];
            end
        end
    end

    assign fr_data_in    = sel_data;
    assign fr_data_avail = (state == ST_SEND) & sel_valid & ~fr_eop;
    assign cons_rise     = fr_consumed & ~cons_d;
    assign und_rise      = fr_underrun & ~und_d;

    always_comb begin
        nxt       = state;
        cnt_nxt   = cnt;
        grant_nxt = grant;
        eop_nxt   = fr_eop;
        rdy_nxt   = '0;
        abt_nxt   = '0;
        arb_adv   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (tx_enable && (|src_valid)) begin
                    grant_nxt = arb_gnt_c;
                    arb_adv   = 1'b1;
                    nxt       = ST_SEND;
                end
            end
            ST_SEND: begin
                // An underrun outranks a byte take in the same cycle.
                if (und_rise) begin
                    abt_nxt   = grant;
                    grant_nxt = '0;
                    cnt_nxt   = GAP_LD;
                    nxt       = POST_ST;
                end else if (cons_rise) begin
                    rdy_nxt = grant;
                    if (sel_last) begin
                        eop_nxt = 1'b1;
                        cnt_nxt = HOLD_LD;
                        nxt     = ST_TAIL;
                    end
                end
            end
            ST_TAIL: begin
                if (cnt <= CNT_W'(1)) begin
                    eop_nxt   = 1'b0;
                    grant_nxt = '0;
                    cnt_nxt   = GAP_LD;
                    nxt       = POST_ST;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            ST_GAP: begin
                if (cnt <= CNT_W'(1)) begin
                    nxt = ST_IDLE;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            default: nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge netclk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            grant        <= '0;
            src_ready    <= '0;
            src_abort    <= '0;
            fr_eop       <= 1'b0;
            fr_flag_fill <= 1'b0;
            busy         <= 1'b0;
            cons_d       <= 1'b0;
            und_d        <= 1'b0;
        end else begin
            state        <= nxt;
            cnt          <= cnt_nxt;
            grant        <= grant_nxt;
            src_ready    <= rdy_nxt;
            src_abort    <= abt_nxt;
            fr_eop       <= eop_nxt;
            fr_flag_fill <= (nxt == ST_GAP) | ((nxt == ST_IDLE) & cfg_flag_idle);
            busy         <= (nxt != ST_IDLE);
            cons_d       <= fr_consumed;
            und_d        <= fr_underrun;
        end
    end

`ifdef TX_SCHED_STATS_EN
    logic frame_done;

    assign frame_done = (state == ST_TAIL) && (nxt != ST_TAIL);

    always_ff @(posedge netclk or posedge reset) begin
        if (reset) begin
            stat_frames <= '0;
            stat_aborts <= '0;
        end else begin
            if (frame_done) begin
                stat_frames <= stat_frames + 16'd1;
            end
            if (|abt_nxt) begin
                stat_aborts <= stat_aborts + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_tx_frame_scheduler.sv
// Directed bench for tx_frame_scheduler (NSRC=2): per-cycle vector table plus hand sequences.
module tb_tx_frame_scheduler;

    logic        netclk;
    logic        reset;
    logic        tx_enable;
    logic        cfg_flag_idle;
    logic [1:0]  src_valid;
    logic [15:0] src_data;
    logic [1:0]  src_last;
    logic [1:0]  src_ready;
    logic [1:0]  src_abort;
    logic [1:0]  grant;
    logic        busy;
    logic [7:0]  fr_data_in;
    logic        fr_data_avail;
    logic        fr_consumed;
    logic        fr_eop;
    logic        fr_flag_fill;
    logic        fr_underrun;
`ifdef TX_SCHED_STATS_EN
    logic [15:0] stat_frames;
    logic [15:0] stat_aborts;
`endif

    tx_frame_scheduler #(.NSRC(2), .EOP_HOLD(40), .GAP_FLAGS(1)) dut (
        .netclk        (netclk),
        .reset         (reset),
        .tx_enable     (tx_enable),
        .cfg_flag_idle (cfg_flag_idle),
        .src_valid     (src_valid),
        .src_data      (src_data),
        .src_last      (src_last),
        .src_ready     (src_ready),
        .src_abort     (src_abort),
        .grant         (grant),
        .busy          (busy),
        .fr_data_in    (fr_data_in),
        .fr_data_avail (fr_data_avail),
        .fr_consumed   (fr_consumed),
        .fr_eop        (fr_eop),
        .fr_flag_fill  (fr_flag_fill),
`ifdef TX_SCHED_STATS_EN
        .stat_frames   (stat_frames),
        .stat_aborts   (stat_aborts),
`endif
        .fr_underrun   (fr_underrun)
    );

    initial netclk = 1'b0;
    always #5 netclk = ~netclk;

    // {grant, busy, src_ready, src_abort, fr_eop, fr_flag_fill, fr_data_in, fr_data_avail}
    logic [17:0] obs;
    assign obs = {grant, busy, src_ready, src_abort, fr_eop, fr_flag_fill, fr_data_in, fr_data_avail};

    typedef struct {
        logic        en;
        logic        fi;
        logic [1:0]  v;
        logic [15:0] d;
        logic [1:0]  l;
        logic        c;
        logic        u;
        logic [17:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t mkv(input logic en, input logic fi, input logic [1:0] v,
                                 input logic [15:0] d, input logic [1:0] l, input logic c,
                                 input logic u, input logic [1:0] g, input logic b,
                                 input logic [1:0] r, input logic [1:0] a, input logic e,
                                 input logic f, input logic [7:0] din, input logic av);
        vec_t t;
        t.en  = en;
        t.fi  = fi;
        t.v   = v;
        t.d   = d;
        t.l   = l;
        t.c   = c;
        t.u   = u;
        t.exp = {g, b, r, a, e, f, din, av};
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge netclk);
        @(negedge netclk);
    endtask

    task automatic run_vecs(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            tx_enable     = vecs[i].en;
            cfg_flag_idle = vecs[i].fi;
            src_valid     = vecs[i].v;
            src_data      = vecs[i].d;
            src_last      = vecs[i].l;
            fr_consumed   = vecs[i].c;
            fr_underrun   = vecs[i].u;
            step();
            check($sformatf("vec%0d", i), 32'(obs), 32'(vecs[i].exp));
        end
    endtask

    int         cnt;
    int         waited;
    logic [1:0] exp_g;

    initial begin
        // Segment A (0..5): 3-byte frame from src0.
        vecs.push_back(mkv(1, 0, 2'b01, 16'h0011, 2'b00, 0, 0, 2'b01, 1, 2'b00, 2'b00, 0, 0, 8'h11, 1));
        vecs.push_back(mkv(1, 0, 2'b01, 16'h0011, 2'b00, 1, 0, 2'b01, 1, 2'b01, 2'b00, 0, 0, 8'h11, 1));
        vecs.push_back(mkv(1, 0, 2'b01, 16'h0022, 2'b00, 0, 0, 2'b01, 1, 2'b00, 2'b00, 0, 0, 8'h22, 1));
        vecs.push_back(mkv(1, 0, 2'b01, 16'h0022, 2'b00, 1, 0, 2'b01, 1, 2'b01, 2'b00, 0, 0, 8'h22, 1));
        vecs.push_back(mkv(1, 0, 2'b01, 16'h0033, 2'b01, 0, 0, 2'b01, 1, 2'b00, 2'b00, 0, 0, 8'h33, 1));
        vecs.push_back(mkv(1, 0, 2'b01, 16'h0033, 2'b01, 1, 0, 2'b01, 1, 2'b01, 2'b00, 1, 0, 8'h33, 0));
        // Segment B (6..11): flag idle and tx_enable gating.
        vecs.push_back(mkv(1, 1, 2'b00, 16'h0000, 2'b00, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 1, 8'h00, 0));
        vecs.push_back(mkv(1, 1, 2'b00, 16'h0000, 2'b00, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 1, 8'h00, 0));
        vecs.push_back(mkv(0, 1, 2'b01, 16'h0055, 2'b00, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 1, 8'h00, 0));
        vecs.push_back(mkv(0, 1, 2'b01, 16'h0055, 2'b00, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 1, 8'h00, 0));
        vecs.push_back(mkv(0, 0, 2'b01, 16'h0055, 2'b00, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 0, 8'h00, 0));
        vecs.push_back(mkv(1, 0, 2'b00, 16'h0055, 2'b00, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 0, 8'h00, 0));
        // Segment C (12..27): src1 0xFF bytes with 2-cycle consumed, then drop valid -> underrun.
        vecs.push_back(mkv(1, 0, 2'b10, 16'hFF00, 2'b00, 0, 0, 2'b10, 1, 2'b00, 2'b00, 0, 0, 8'hFF, 1));
        vecs.push_back(mkv(1, 0, 2'b10, 16'hFF00, 2'b00, 1, 0, 2'b10, 1, 2'b10, 2'b00, 0, 0, 8'hFF, 1));
        vecs.push_back(mkv(1, 0, 2'b10, 16'hFF00, 2'b00, 1, 0, 2'b10, 1, 2'b00, 2'b00, 0, 0, 8'hFF, 1));
        vecs.push_back(mkv(1, 0, 2'b10, 16'hFF00, 2'b00, 0, 0, 2'b10, 1, 2'b00, 2'b00, 0, 0, 8'hFF, 1));
        vecs.push_back(mkv(1, 0, 2'b10, 16'hFF00, 2'b00, 1, 0, 2'b10, 1, 2'b10, 2'b00, 0, 0, 8'hFF, 1));
        vecs.push_back(mkv(1, 0, 2'b10, 16'hFF00, 2'b00, 1, 0, 2'b10, 1, 2'b00, 2'b00, 0, 0, 8'hFF, 1));
        vecs.push_back(mkv(1, 0, 2'b00, 16'hFF00, 2'b00, 0, 0, 2'b10, 1, 2'b00, 2'b00, 0, 0, 8'hFF, 0));
        vecs.push_back(mkv(1, 0, 2'b00, 16'hFF00, 2'b00, 0, 1, 2'b00, 1, 2'b00, 2'b10, 0, 1, 8'h00, 0));
        for (int k = 0; k < 7; k++) begin
            vecs.push_back(mkv(1, 0, 2'b00, 16'hFF00, 2'b00, 0, 1, 2'b00, 1, 2'b00, 2'b00, 0, 1, 8'h00, 0));
        end
        vecs.push_back(mkv(1, 0, 2'b00, 16'hFF00, 2'b00, 0, 1, 2'b00, 0, 2'b00, 2'b00, 0, 0, 8'h00, 0));
        // Segment D (28..30): sticky underrun gives no second abort; 1-byte-style finish into TAIL.
        vecs.push_back(mkv(1, 0, 2'b01, 16'h0044, 2'b00, 0, 1, 2'b01, 1, 2'b00, 2'b00, 0, 0, 8'h44, 1));
        vecs.push_back(mkv(1, 0, 2'b01, 16'h0044, 2'b00, 0, 1, 2'b01, 1, 2'b00, 2'b00, 0, 0, 8'h44, 1));
        vecs.push_back(mkv(1, 0, 2'b01, 16'h0044, 2'b01, 1, 1, 2'b01, 1, 2'b01, 2'b00, 1, 0, 8'h44, 0));

        reset         = 1'b1;
        tx_enable     = 1'b0;
        cfg_flag_idle = 1'b0;
        src_valid     = '0;
        src_data      = '0;
        src_last      = '0;
        fr_consumed   = 1'b0;
        fr_underrun   = 1'b0;
        repeat (2) @(negedge netclk);
        check("reset_state", 32'(obs), 32'd0);
        reset = 1'b0;

        run_vecs(0, 5);

        // eop hold length and flag gap after a completed frame
        src_valid   = 2'b00;
        fr_consumed = 1'b0;
        cnt = 1;
        for (int i = 0; i < 200; i++) begin
            step();
            if (fr_eop) cnt++;
            else break;
        end
        check("eop_hold_len", 32'(cnt), 32'd40);
        check("gap_entry", 32'({grant, busy, fr_flag_fill}), 32'({2'b00, 1'b1, 1'b1}));
        cnt = 1;
        for (int i = 0; i < 200; i++) begin
            step();
            if (fr_flag_fill) cnt++;
            else break;
        end
        check("gap_len", 32'(cnt), 32'd8);
        check("idle_after_gap", 32'({grant, busy}), 32'd0);

        run_vecs(6, 30);
`ifdef TX_SCHED_STATS_EN
        check("stat_frames", 32'(stat_frames), 32'd1);
        check("stat_aborts", 32'(stat_aborts), 32'd1);
`endif

        // asynchronous reset in the middle of TAIL
        src_valid   = 2'b00;
        src_last    = 2'b00;
        fr_consumed = 1'b0;
        repeat (3) step();
        check("tail_before_reset", 32'({fr_eop, busy}), 32'b11);
        @(posedge netclk);
        #2 reset = 1'b1;
        #1;
        check("async_reset_outputs", 32'(obs), 32'd0);
        fr_underrun = 1'b0;
        repeat (2) @(negedge netclk);
`ifdef TX_SCHED_STATS_EN
        check("stat_frames_after_reset", 32'(stat_frames), 32'd0);
`endif
        reset = 1'b0;

        // both sources request continuously: grants alternate 0,1,0,1
        tx_enable     = 1'b1;
        cfg_flag_idle = 1'b0;
        src_valid     = 2'b11;
        src_data      = 16'hB1A0;
        src_last      = 2'b11;
        for (int k = 0; k < 4; k++) begin
            exp_g  = (k % 2 == 0) ? 2'b01 : 2'b10;
            waited = 0;
            while (grant == 2'b00 && waited < 100) begin
                step();
                waited++;
            end
            check($sformatf("rr_grant%0d", k), 32'(grant), 32'(exp_g));
            check($sformatf("rr_data%0d", k), 32'(fr_data_in), exp_g[0] ? 32'hA0 : 32'hB1);
            fr_consumed = 1'b1;
            step();
            check($sformatf("rr_ready%0d", k), 32'(src_ready), 32'(exp_g));
            fr_consumed = 1'b0;
            waited = 0;
            while (grant != 2'b00 && waited < 100) begin
                step();
                waited++;
            end
            check($sformatf("rr_release%0d", k), 32'(grant), 32'd0);
        end
        src_valid = 2'b00;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
